// File: rtl/lcv_mul32_seq.sv
// rtl/lcv_mul32_seq.sv - sequential unsigned multiplier, one half-width partial product per clock
// Optional LCV_MUL32_SEQ_SKIP_ZERO_EN: skip partial products whose high operand half is zero.
module lcv_mul32_seq #(
  parameter int HALF_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inp_valid,
  output logic                    inp_ready,
  input  logic [2*HALF_WIDTH-1:0] inp_a,
  input  logic [2*HALF_WIDTH-1:0] inp_b,
  output logic                    outp_valid,
  input  logic                    outp_ready,
  output logic [4*HALF_WIDTH-1:0] outp_data
);

  localparam int W  = 2 * HALF_WIDTH;
  localparam int PW = 4 * HALF_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [1:0]      step_q, step_d;

  logic [HALF_WIDTH-1:0] op_a, op_b;
  logic [W-1:0]          pp;
  logic [PW-1:0]         pp_ext, pp_sh;
  logic                  more_steps;
  logic [1:0]            next_step;
  logic                  accept;

  assign inp_ready  = (state_q == IDLE) || ((state_q == DONE) && outp_ready);
  assign outp_valid = (state_q == DONE);
  assign outp_data  = acc_q;
  assign accept     = inp_valid && inp_ready;

  // step[1] selects the high half of a, step[0] the high half of b
  always_comb begin
    op_a   = step_q[1] ? a_q[W-1:HALF_WIDTH] : a_q[HALF_WIDTH-1:0];
    op_b   = step_q[0] ? b_q[W-1:HALF_WIDTH] : b_q[HALF_WIDTH-1:0];
    pp     = {{HALF_WIDTH{1'b0}}, op_a} * {{HALF_WIDTH{1'b0}}, op_b};
    pp_ext = {{W{1'b0}}, pp};
    case (step_q)
      2'd0:    pp_sh = pp_ext;
      2'd3:    pp_sh = pp_ext << (2 * HALF_WIDTH);
      default: pp_sh = pp_ext << HALF_WIDTH;
    endcase
  end

`ifdef LCV_MUL32_SEQ_SKIP_ZERO_EN
  logic a_hi_zero, b_hi_zero;
  assign a_hi_zero = (a_q[W-1:HALF_WIDTH] == '0);
  assign b_hi_zero = (b_q[W-1:HALF_WIDTH] == '0);

  // Jump to the next step whose partial product can be non-zero
  always_comb begin
    more_steps = 1'b0;
    next_step  = 2'd0;
    case (step_q)
      2'd0: begin
        if (!b_hi_zero) begin
          more_steps = 1'b1;
          next_step  = 2'd1;
        end else if (!a_hi_zero) begin
          more_steps = 1'b1;
          next_step  = 2'd2;
        end
      end
      2'd1: begin
        more_steps = !a_hi_zero;
        next_step  = 2'd2;
      end
      2'd2: begin
        more_steps = !b_hi_zero;
        next_step  = 2'd3;
      end
      default: begin
        more_steps = 1'b0;
        next_step  = 2'd0;
      end
    endcase
  end
`else
  always_comb begin
    more_steps = (step_q != 2'd3);
    next_step  = step_q + 2'd1;
  end
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    case (state_q)
      CALC: begin
        acc_d = acc_q + pp_sh;
        if (more_steps) begin
          step_d = next_step;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (outp_ready && !inp_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = state_q;
      end
    endcase
    // An accept in DONE doubles as the output handshake: no idle bubble
    if (accept) begin
      a_d     = inp_a;
      b_d     = inp_b;
      acc_d   = '0;
      step_d  = 2'd0;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      step_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      step_q  <= step_d;
    end
  end

endmodule

// File: tb/tb_lcv_mul32_seq.sv
// tb/tb_lcv_mul32_seq.sv - randomized self-checking bench for lcv_mul32_seq
module tb_lcv_mul32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        inp_valid;
  logic        inp_ready;
  logic [31:0] inp_a;
  logic [31:0] inp_b;
  logic        outp_valid;
  logic        outp_ready;
  logic [63:0] outp_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lcv_mul32_seq #(.HALF_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .inp_valid  (inp_valid),
    .inp_ready  (inp_ready),
    .inp_a      (inp_a),
    .inp_b      (inp_b),
    .outp_valid (outp_valid),
    .outp_ready (outp_ready),
    .outp_data  (outp_data)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_product(input logic [31:0] a, input logic [31:0] b);
    longint unsigned x, y;
    x = longint'(a);
    y = longint'(b);
    return x * y;
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef LCV_MUL32_SEQ_SKIP_ZERO_EN
    bit a_small, b_small;
    a_small = (a < 32'h0001_0000);
    b_small = (b < 32'h0001_0000);
    if (a_small && b_small) return 1;
    if (a_small || b_small) return 2;
`endif
    return 4;
  endfunction

  // Drive a pair and return just after the edge that accepted it
  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!inp_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!inp_ready) check("ready_timeout", 64'(inp_ready), 64'd1);
    inp_valid = 1'b1;
    inp_a     = a;
    inp_b     = b;
    @(posedge clk); #1;
    inp_valid = 1'b0;
    inp_a     = $urandom;
    inp_b     = $urandom;
  endtask

  task automatic await_result(input logic [31:0] a, input logic [31:0] b, input string tag);
    int n = 0;
    check({tag, "_calc_valid"}, 64'(outp_valid), 64'd0);
    check({tag, "_calc_ready"}, 64'(inp_ready), 64'd0);
    do begin
      @(posedge clk); #1;
      n++;
    end while (!outp_valid && n < 20);
    check({tag, "_latency"}, 64'(n), 64'(ref_latency(a, b)));
    check({tag, "_data"}, outp_data, ref_product(a, b));
  endtask

  task automatic drain(input logic [63:0] exp, input int hold, input string tag);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 64'(outp_valid), 64'd1);
      check({tag, "_hold_data"}, outp_data, exp);
      check({tag, "_hold_ready"}, 64'(inp_ready), 64'd0);
    end
    outp_ready = 1'b1;
    @(posedge clk); #1;
    outp_ready = 1'b0;
    check({tag, "_drained"}, 64'(outp_valid), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold, input string tag);
    issue(a, b);
    await_result(a, b, tag);
    drain(ref_product(a, b), hold, tag);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst        = 1'b0;
    inp_valid  = 1'b0;
    outp_ready = 1'b0;
    inp_a      = '0;
    inp_b      = '0;

    #23;
    check("rst_valid", 64'(outp_valid), 64'd0);
    check("rst_data", outp_data, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    check("rst_ready", 64'(inp_ready), 64'd1);

    // First accept lands on the first edge after release
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "full");
    check("full_const", ref_product(32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
    run_op(32'h0001_0000, 32'h0001_0000, 0, "cross");
    run_op(32'd3, 32'd5, 10, "small_bp");

    // Back-to-back: handshake and new accept on the same edge
    issue(32'h1234_5678, 32'hDEAD_BEEF);
    await_result(32'h1234_5678, 32'hDEAD_BEEF, "b2b_first");
    outp_ready = 1'b1;
    issue(32'd7, 32'd9);
    outp_ready = 1'b0;
    await_result(32'd7, 32'd9, "b2b_second");
    check("b2b_value", outp_data, 64'h3F);
    drain(64'h3F, 0, "b2b_second");

    // Reset while step 2 is pending
    issue(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    check("midrst_valid", 64'(outp_valid), 64'd0);
    check("midrst_data", outp_data, 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_hold_valid", 64'(outp_valid), 64'd0);
    end
    rst = 1'b1;
    check("midrst_ready", 64'(inp_ready), 64'd1);
    run_op(32'd2, 32'd2, 1, "post_rst");

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom % 4)
        0: ra = ra & 32'h0000_FFFF;
        1: rb = rb & 32'h0000_FFFF;
        2: begin
          ra = ra & 32'h0000_FFFF;
          rb = rb & 32'h0000_FFFF;
        end
        default: ;
      endcase
      run_op(ra, rb, int'($urandom % 4), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcv_mul32_seq.md
LCV_MUL32_SEQ -- requirements
Module: lcv_mul32_seq

Interface
REQ-001 SHALL provide parameter HALF_WIDTH, default 16, which sets the half-operand width; the operand width is 2*HALF_WIDTH.
REQ-002 SHALL provide port clk: input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst: input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL provide port inp_valid: input, 1 bit, operand pair present.
REQ-005 SHALL provide port inp_ready: output, 1 bit, block can accept an operand pair.
REQ-006 SHALL provide port inp_a: input, 2*HALF_WIDTH bits, unsigned multiplicand.
REQ-007 SHALL provide port inp_b: input, 2*HALF_WIDTH bits, unsigned multiplier.
REQ-008 SHALL provide port outp_valid: output, 1 bit, product present.
REQ-009 SHALL provide port outp_ready: input, 1 bit, downstream accepts the product.
REQ-010 SHALL provide port outp_data: output, 4*HALF_WIDTH bits, product inp_a*inp_b.

Function
REQ-011 SHALL compute the full unsigned product by accumulating HALF_WIDTH x HALF_WIDTH partial products, one per clock, into a 4*HALF_WIDTH-bit accumulator.
REQ-012 SHALL implement a state machine with states IDLE, CALC and DONE.
REQ-013 Accept SHALL occur when inp_valid and inp_ready are both high at a rising edge; on accept, inp_a and inp_b SHALL be registered, the accumulator cleared, the step counter set to the first step, and the state set to CALC.
REQ-014 inp_ready SHALL be high in IDLE, and in DONE when outp_ready is high; it SHALL be low in CALC.
REQ-015 In CALC, one step SHALL execute per cycle, in this fixed order:
- step 0: acc += a_lo*b_lo
- step 1: acc += (a_lo*b_hi) << HALF_WIDTH
- step 2: acc += (a_hi*b_lo) << HALF_WIDTH
- step 3: acc += (a_hi*b_hi) << 2*HALF_WIDTH
REQ-016 All additions SHALL be modulo 2^(4*HALF_WIDTH); the true product never exceeds this width, so no overflow flag exists.
REQ-017 After the last executed step, the state SHALL become DONE, outp_valid SHALL be high, and outp_data SHALL equal the final accumulator value.
REQ-018 Latency SHALL be 4 edges from the accept edge to outp_valid when all steps execute (outp_valid visible after accept edge + 4).
REQ-019 In DONE, outp_valid and outp_data SHALL hold stable until outp_ready is high at an edge.
REQ-020 On output handshake without a same-edge accept, the state SHALL become IDLE and outp_valid SHALL go low.
REQ-021 On output handshake with inp_valid high at the same edge, the new pair SHALL be accepted and the state SHALL go directly to CALC, with no idle bubble.
REQ-022 inp_a and inp_b changes outside the accept edge SHALL NOT affect the result in progress.
REQ-023 outp_data SHALL be registered and driven only from the accumulator, with no combinational path from inp_* to outp_*.

Reset
REQ-024 When rst is low, asynchronously: state SHALL be IDLE; outp_valid SHALL be 0; outp_data, the accumulator, the operand registers and the step counter SHALL be 0; inp_ready SHALL be 1 once rst is high.
REQ-025 Reset asserted mid-CALC or in DONE SHALL discard the operation; no outp_valid SHALL follow for it.
REQ-026 The first accept SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-027 With macro LCV_MUL32_SEQ_SKIP_ZERO_EN defined, steps whose partial product is known zero SHALL be skipped:
- a_hi==0 skips steps 2 and 3
- b_hi==0 skips steps 1 and 3
- latency is therefore 1, 2 or 4 edges
REQ-028 Without LCV_MUL32_SEQ_SKIP_ZERO_EN, all four steps SHALL always execute and latency SHALL be exactly 4; the product value is identical in both builds.

Verification
REQ-029 Full-range case: accept 0xFFFFFFFF * 0xFFFFFFFF -> outp_data 0xFFFFFFFE00000001, with outp_valid 4 edges after the accept edge.
REQ-030 Cross-half case: accept 0x00010000 * 0x00010000 -> outp_data 0x0000000100000000 after 4 edges in both builds.
REQ-031 Small operands: accept 3 * 5 -> outp_data 0xF; latency 1 edge with LCV_MUL32_SEQ_SKIP_ZERO_EN, 4 edges without.
REQ-032 Backpressure: hold outp_ready low for 10 cycles in DONE -> outp_valid stays high, outp_data stays stable, and inp_ready stays low.
REQ-033 Back-to-back: in DONE, raise outp_ready and inp_valid with 7*9 -> the first product is consumed, 63 (0x3F) is produced next, and there is no IDLE cycle between them.
REQ-034 Reset mid-operation: pull rst low during CALC step 2 -> outp_valid=0 and outp_data=0 immediately; after release, inp_ready=1 and 2*2 yields 4.
